// File: rtl/dm_arb.sv
// Two-port data-memory arbiter: a CPU port and a DMA/debug port share one
// data memory. Each access takes two cycles: a grant in IDLE, then one
// ACCESS cycle that drives the memory. A valid or error pulse goes back to
// the requester in the cycle after ACCESS.
module dm_arb #(
  parameter int unsigned PRIO_CPU    = 0,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  // CPU port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_type,
  output logic        c_gnt,
  output logic        c_valid,
  output logic        c_err,
  // DMA/debug port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic        d_gnt,
  output logic        d_valid,
  output logic        d_err,
  // Shared load result
  output logic [31:0] rdata,
  // Data-memory side
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic [2:0]  m_type,
  input  logic [31:0] m_dout
);

  // Access-size codes shared with the core's control encoding
  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;

  typedef enum logic {StIdle, StAccess} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_last_dma;   // 1: DMA won the most recent grant
  logic        r_port_dma;   // latched port id, 1: DMA
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_type;
  logic [31:0] r_rdata;
  logic        r_c_valid;
  logic        r_c_err;
  logic        r_d_valid;
  logic        r_d_err;

  logic        w_pick_dma;
  logic        w_c_gnt;
  logic        w_d_gnt;
  logic        w_grant;
  logic        w_access;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_err;

  // Pick the winning port: lone requester wins, ties go by mode
  always_comb begin
    w_pick_dma = ~c_req;
    if (c_req && d_req) begin
      if (PRIO_CPU != 0) begin
        w_pick_dma = 1'b0;
      end else begin
        w_pick_dma = ~r_last_dma;
      end
    end
  end

  // Next state and combinational grants
  always_comb begin
    w_state_d = r_state;
    w_c_gnt   = 1'b0;
    w_d_gnt   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (c_req || d_req) begin
          w_state_d = StAccess;
          w_c_gnt   = ~w_pick_dma;
          w_d_gnt   = w_pick_dma;
        end
      end
      StAccess: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Error decode of the latched command: alignment by size, then range
  always_comb begin
    w_misaligned = 1'b0;
    case (r_type)
      DM_WORD:                           w_misaligned = |r_addr[1:0];
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: w_misaligned = r_addr[0];
      default:                           w_misaligned = 1'b0;
    endcase
    w_out_of_range = ({2'b00, r_addr[31:2]} >= DEPTH_WORDS);
    w_err          = w_misaligned | w_out_of_range;
  end

  assign w_access = (r_state == StAccess);
  assign w_grant  = w_c_gnt | w_d_gnt;

  assign c_gnt   = w_c_gnt;
  assign d_gnt   = w_d_gnt;
  assign c_valid = r_c_valid;
  assign c_err   = r_c_err;
  assign d_valid = r_d_valid;
  assign d_err   = r_d_err;
  assign rdata   = r_rdata;

  // State register drives m_we, so an asynchronous reset kills the strobe at once
  assign m_we   = w_access & r_we & ~w_err;
  assign m_addr = r_addr;
  assign m_din  = r_wdata;
  assign m_type = r_type;

  // FSM state and last-winner tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_last_dma <= 1'b1;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_last_dma <= w_pick_dma;
      end
    end
  end

  // Latch the granted port's command
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_port_dma <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_type     <= '0;
    end else if (w_grant) begin
      r_port_dma <= w_pick_dma;
      r_we       <= w_pick_dma ? d_we    : c_we;
      r_addr     <= w_pick_dma ? d_addr  : c_addr;
      r_wdata    <= w_pick_dma ? d_wdata : c_wdata;
      r_type     <= w_pick_dma ? d_type  : c_type;
    end
  end

  // Completion pulses and load result at the end of ACCESS
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_c_valid <= 1'b0;
      r_c_err   <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_err   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_c_valid <= w_access & ~r_port_dma & ~w_err;
      r_c_err   <= w_access & ~r_port_dma &  w_err;
      r_d_valid <= w_access &  r_port_dma & ~w_err;
      r_d_err   <= w_access &  r_port_dma &  w_err;
      if (w_access && !w_err && !r_we) begin
        r_rdata <= m_dout;
      end
    end
  end

endmodule

// File: tb/tb_dm_arb.sv
// Bench for dm_arb: a transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_dm_arb;

  localparam int unsigned DEPTH = 1024;
  localparam logic [2:0] DM_WORD = 3'b000;
  localparam logic [2:0] DM_HALF = 3'b001;
  localparam logic [2:0] DM_BYTE = 3'b011;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_type, d_type;
  logic        c_gnt, c_valid, c_err, d_gnt, d_valid, d_err, m_we;
  logic [31:0] rdata, m_addr, m_din, m_dout;
  logic [2:0]  m_type;

  // Second instance in fixed-priority mode
  logic        p_c_req, p_d_req;
  logic        p_c_gnt, p_c_valid, p_c_err, p_d_gnt, p_d_valid, p_d_err, p_m_we;
  logic [31:0] p_rdata, p_m_addr, p_m_din;
  logic [2:0]  p_m_type;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dm_arb #(.PRIO_CPU(0), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_type(c_type),
    .c_gnt(c_gnt), .c_valid(c_valid), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err),
    .rdata(rdata), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_type(m_type),
    .m_dout(m_dout)
  );

  dm_arb #(.PRIO_CPU(1), .DEPTH_WORDS(DEPTH)) dut_prio (
    .clk(clk), .rstn(rstn),
    .c_req(p_c_req), .c_we(1'b0), .c_addr(32'h0), .c_wdata(32'h0), .c_type(DM_WORD),
    .c_gnt(p_c_gnt), .c_valid(p_c_valid), .c_err(p_c_err),
    .d_req(p_d_req), .d_we(1'b0), .d_addr(32'h4), .d_wdata(32'h0), .d_type(DM_WORD),
    .d_gnt(p_d_gnt), .d_valid(p_d_valid), .d_err(p_d_err),
    .rdata(p_rdata), .m_we(p_m_we), .m_addr(p_m_addr), .m_din(p_m_din), .m_type(p_m_type),
    .m_dout(32'h0)
  );

  // Environment memory seen by the DUT: combinational read, write on the edge
  logic [31:0] mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h1000_0000 + i;
  assign m_dout = mem[m_addr[11:2]];
  always @(posedge clk) if (m_we) mem[m_addr[11:2]] <= m_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic        dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
  } cmd_t;

  logic [31:0] mdl_mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = 32'h1000_0000 + i;

  logic        mdl_busy;      // an accepted command is being performed this cycle
  cmd_t        mdl_cmd;
  logic        mdl_last_dma;
  logic [31:0] mdl_rdata;
  logic [1:0]  mdl_valid;     // index 0: CPU, 1: DMA
  logic [1:0]  mdl_err;

  function automatic logic acc_err(input cmd_t c);
    int unsigned size;
    size = (c.typ == 3'd0) ? 4 : ((c.typ == 3'd1 || c.typ == 3'd2) ? 2 : 1);
    return ((c.addr % size) != 0) || ((c.addr / 4) >= DEPTH);
  endfunction

  // Lone requester wins; on a tie the port that lost last time wins
  function automatic logic winner_dma(input logic cr, input logic dr, input logic last_dma);
    if (cr && dr) return last_dma ? 1'b0 : 1'b1;
    return dr;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdl_busy     <= 1'b0;
      mdl_last_dma <= 1'b1;
      mdl_rdata    <= '0;
      mdl_valid    <= '0;
      mdl_err      <= '0;
    end else begin
      mdl_valid <= '0;
      mdl_err   <= '0;
      if (mdl_busy) begin
        mdl_busy <= 1'b0;
        if (acc_err(mdl_cmd)) begin
          mdl_err[mdl_cmd.dma] <= 1'b1;
        end else begin
          mdl_valid[mdl_cmd.dma] <= 1'b1;
          if (mdl_cmd.we) mdl_mem[mdl_cmd.addr[11:2]] <= mdl_cmd.wdata;
          else            mdl_rdata <= mdl_mem[mdl_cmd.addr[11:2]];
        end
      end else if (c_req || d_req) begin
        mdl_busy     <= 1'b1;
        mdl_last_dma <= winner_dma(c_req, d_req, mdl_last_dma);
        mdl_cmd      <= winner_dma(c_req, d_req, mdl_last_dma) ?
                        {1'b1, d_we, d_addr, d_wdata, d_type} :
                        {1'b0, c_we, c_addr, c_wdata, c_type};
      end
    end
  end

  logic e_any, e_dma, e_we;
  assign e_any = !mdl_busy && (c_req || d_req);
  assign e_dma = winner_dma(c_req, d_req, mdl_last_dma);
  assign e_we  = mdl_busy && mdl_cmd.we && !acc_err(mdl_cmd);

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_c_gnt", {31'b0, c_gnt}, 0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 0);
      chk("rst_c_valid", {31'b0, c_valid}, 0);
      chk("rst_c_err", {31'b0, c_err}, 0);
      chk("rst_d_valid", {31'b0, d_valid}, 0);
      chk("rst_d_err", {31'b0, d_err}, 0);
      chk("rst_m_we", {31'b0, m_we}, 0);
      chk("rst_rdata", rdata, 0);
    end else begin
      chk("mdl_c_gnt", {31'b0, c_gnt}, {31'b0, e_any && !e_dma});
      chk("mdl_d_gnt", {31'b0, d_gnt}, {31'b0, e_any && e_dma});
      chk("mdl_m_we", {31'b0, m_we}, {31'b0, e_we});
      if (mdl_busy) begin
        chk("mdl_m_addr", m_addr, mdl_cmd.addr);
        chk("mdl_m_din", m_din, mdl_cmd.wdata);
        chk("mdl_m_type", {29'b0, m_type}, {29'b0, mdl_cmd.typ});
      end
      chk("mdl_c_valid", {31'b0, c_valid}, {31'b0, mdl_valid[0]});
      chk("mdl_c_err", {31'b0, c_err}, {31'b0, mdl_err[0]});
      chk("mdl_d_valid", {31'b0, d_valid}, {31'b0, mdl_valid[1]});
      chk("mdl_d_err", {31'b0, d_err}, {31'b0, mdl_err[1]});
      chk("mdl_rdata", rdata, mdl_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] w, input logic [2:0] t);
    c_req = req; c_we = we; c_addr = a; c_wdata = w; c_type = t;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] w, input logic [2:0] t);
    d_req = req; d_we = we; d_addr = a; d_wdata = w; d_type = t;
  endtask

  // Request, wait (bounded) for grant, then check the completion pulse two cycles later
  task automatic op(input logic dma, input logic we, input logic [31:0] a, input logic [31:0] w,
                    input logic [2:0] t, input logic exp_err, input string name);
    logic got;
    got = 1'b0;
    if (dma) set_d(1'b1, we, a, w, t);
    else     set_c(1'b1, we, a, w, t);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dma ? d_gnt : c_gnt) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_gnt: no grant within 20 cycles, expected a grant", name);
    end
    tick();
    if (dma) set_d(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    else     set_c(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    tick();
    @(negedge clk);
    chk({name, "_valid"}, {31'b0, dma ? d_valid : c_valid}, {31'b0, !exp_err});
    chk({name, "_err"}, {31'b0, dma ? d_err : c_err}, {31'b0, exp_err});
  endtask

  initial begin
    set_c(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    set_d(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    p_c_req = 1'b0;
    p_d_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("lit_rst_rdata", rdata, 32'h0);
    chk("lit_rst_m_we", {31'b0, m_we}, 0);
    tick();
    rstn = 1'b1;

    // CPU word write then read back
    set_c(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, DM_WORD);
    @(negedge clk); chk("wr_c_gnt", {31'b0, c_gnt}, 1);
    tick(); set_c(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    @(negedge clk); chk("wr_m_we", {31'b0, m_we}, 1); chk("wr_m_addr", m_addr, 32'h10);
    tick();
    @(negedge clk); chk("wr_c_valid", {31'b0, c_valid}, 1);
    tick(); set_c(1'b1, 1'b0, 32'h10, 32'h0, DM_WORD);
    @(negedge clk); chk("rd_c_gnt", {31'b0, c_gnt}, 1);
    tick(); set_c(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    tick();
    @(negedge clk); chk("rd_c_valid", {31'b0, c_valid}, 1); chk("rd_rdata", rdata, 32'hDEAD_BEEF);

    // Misalignment and size rules
    tick();
    op(1'b0, 1'b1, 32'h6, 32'h1111_1111, DM_WORD, 1'b1, "mis_wr_word");
    tick();
    op(1'b0, 1'b0, 32'h6, 32'h0, DM_WORD, 1'b1, "mis_rd_word");
    chk("mis_rdata_hold", rdata, 32'hDEAD_BEEF);
    tick();
    op(1'b0, 1'b0, 32'h3, 32'h0, DM_HALF, 1'b1, "mis_half");
    tick();
    op(1'b0, 1'b0, 32'h3, 32'h0, DM_BYTE, 1'b0, "byte_ok");
    chk("byte_rdata", rdata, 32'h1000_0000);

    // Out-of-range DMA write must not alias onto word 0
    tick();
    op(1'b1, 1'b1, 32'h1000, 32'hBAD0_BAD0, DM_WORD, 1'b1, "oor_wr");
    tick();
    op(1'b1, 1'b0, 32'h0, 32'h0, DM_WORD, 1'b0, "rd_word0");
    chk("oor_no_write", rdata, 32'h1000_0000);

    // DMA completion in the same cycle as a CPU grant
    tick(); set_d(1'b1, 1'b0, 32'h20, 32'h0, DM_WORD);
    @(negedge clk); chk("b2b_d_gnt", {31'b0, d_gnt}, 1);
    tick(); set_d(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    tick(); set_c(1'b1, 1'b0, 32'h30, 32'h0, DM_WORD);
    @(negedge clk);
    chk("b2b_d_valid", {31'b0, d_valid}, 1);
    chk("b2b_c_gnt", {31'b0, c_gnt}, 1);
    chk("b2b_rdata_dma", rdata, 32'h1000_0008);
    tick(); set_c(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    @(negedge clk); chk("b2b_rdata_hold", rdata, 32'h1000_0008);
    tick();
    @(negedge clk); chk("b2b_c_valid", {31'b0, c_valid}, 1); chk("b2b_rdata_cpu", rdata, 32'h1000_000C);

    // Reset asserted in the middle of a write access
    tick(); set_c(1'b1, 1'b1, 32'h40, 32'h1234_5678, DM_WORD);
    @(negedge clk); chk("rr_c_gnt", {31'b0, c_gnt}, 1);
    tick(); set_c(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    #1; chk("rr_m_we_before", {31'b0, m_we}, 1);
    rstn = 1'b0;
    #1; chk("rr_m_we_drop", {31'b0, m_we}, 0);
    tick();
    tick(); rstn = 1'b1;
    @(negedge clk); chk("rr_no_valid", {31'b0, c_valid}, 0); chk("rr_rdata", rdata, 32'h0);
    tick();
    @(negedge clk); chk("rr_no_valid2", {31'b0, c_valid}, 0);
    tick();
    op(1'b0, 1'b0, 32'h40, 32'h0, DM_WORD, 1'b0, "rr_readback");
    chk("rr_not_written", rdata, 32'h1000_0010);

    // Held simultaneous requests from reset: alternation vs fixed CPU priority
    tick(); rstn = 1'b0;
    tick();
    set_c(1'b1, 1'b0, 32'h20, 32'h0, DM_WORD);
    set_d(1'b1, 1'b0, 32'h24, 32'h0, DM_WORD);
    p_c_req = 1'b1;
    p_d_req = 1'b1;
    rstn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("rr_c_gnt_%0d", k), {31'b0, c_gnt}, {31'b0, (k % 4) == 0});
      chk($sformatf("rr_d_gnt_%0d", k), {31'b0, d_gnt}, {31'b0, (k % 4) == 2});
      chk($sformatf("prio_c_gnt_%0d", k), {31'b0, p_c_gnt}, {31'b0, (k % 2) == 0 && k < 8});
      chk($sformatf("prio_d_gnt_%0d", k), {31'b0, p_d_gnt}, {31'b0, k == 8});
      tick();
      if (k == 7) p_c_req = 1'b0;
    end
    set_c(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    set_d(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    p_d_req = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
